// File: rtl/booth_multiplicador_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    D_ZERO = 3'd0,
    D_POS1 = 3'd1,
    D_POS2 = 3'd2,
    D_NEG1 = 3'd3,
    D_NEG2 = 3'd4
  } booth_digit_t;

  // One iteration per pair of bits of the (width+2)-bit extended multiplier.
  function automatic int steps_for(input int width);
    return (width + 2) / 2;
  endfunction

  // Window is {q[i+1], q[i], q[i-1]}.
  function automatic booth_digit_t decode_digit(input logic [2:0] window);
    booth_digit_t d;
    case (window)
      3'b001, 3'b010: d = D_POS1;
      3'b011:         d = D_POS2;
      3'b100:         d = D_NEG2;
      3'b101, 3'b110: d = D_NEG1;
      default:        d = D_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_multiplicador_if.sv
// Request/response bundle between CPU control and the multiplier.
interface booth_multiplicador_if #(
  parameter int WIDTH = 16
);
  logic                   Start;
  logic                   Signed;
  logic [WIDTH-1:0]       Multiplicando;
  logic [WIDTH-1:0]       Multiplicador;
  logic                   Busy;
  logic                   Done;
  logic [2*WIDTH-1:0]     Produto;

  modport master (
    output Start, Signed, Multiplicando, Multiplicador,
    input  Busy, Done, Produto
  );

  modport slave (
    input  Start, Signed, Multiplicando, Multiplicador,
    output Busy, Done, Produto
  );
endinterface

// File: rtl/booth_multiplicador_recode.sv
// Radix-4 Booth recoder: selects 0, +-M or +-2M as a (WIDTH+3)-bit addend.
module booth_recode
  import mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       i_window,
  input  logic [WIDTH+1:0] i_mcand,
  output logic [WIDTH+2:0] o_addend
);

  localparam logic [WIDTH+2:0] LP_ONE = {{(WIDTH+2){1'b0}}, 1'b1};

  booth_digit_t     w_digit;
  logic [WIDTH+2:0] w_m;
  logic [WIDTH+2:0] w_m2;

  assign w_digit = decode_digit(i_window);
  assign w_m     = {i_mcand[WIDTH+1], i_mcand};
  assign w_m2    = {i_mcand, 1'b0};

  // Pick the partial-product addend; negatives as one's complement plus one.
  always_comb begin
    o_addend = '0;
    case (w_digit)
      D_POS1:  o_addend = w_m;
      D_POS2:  o_addend = w_m2;
      D_NEG1:  o_addend = ~w_m + LP_ONE;
      D_NEG2:  o_addend = ~w_m2 + LP_ONE;
      default: o_addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_multiplicador.sv
// Sequential radix-4 Booth multiplier, signed/unsigned, Start/Busy/Done.
// state | meaning
// IDLE  | waiting for Start
// CALC  | one Booth step per cycle, STEPS cycles
// DONE  | Produto valid, Done pulse; Start here chains the next operation
module booth_multiplicador
  import mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  booth_multiplicador_if.slave bus
);

  localparam int STEPS = steps_for(WIDTH);
  localparam int CW    = $clog2(STEPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $fatal(1, "booth_multiplicador: WIDTH must be even and >= 4");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_step;
  logic               w_last;
  logic [WIDTH+1:0]   r_mcand;
  logic [WIDTH+1:0]   r_acc;
  logic [WIDTH+2:0]   r_mplr;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH+1:0]   w_mcand_ext;
  logic [WIDTH+1:0]   w_mplr_ext;
  logic [WIDTH+2:0]   w_addend;
  logic [WIDTH+2:0]   w_sum;
  logic [WIDTH+1:0]   w_acc_nxt;
  logic [WIDTH+2:0]   w_mplr_nxt;

  assign w_mcand_ext = {{2{bus.Signed & bus.Multiplicando[WIDTH-1]}}, bus.Multiplicando};
  assign w_mplr_ext  = {{2{bus.Signed & bus.Multiplicador[WIDTH-1]}}, bus.Multiplicador};

  booth_recode #(.WIDTH(WIDTH)) u_recode (
    .i_window (r_mplr[2:0]),
    .i_mcand  (r_mcand),
    .o_addend (w_addend)
  );

  // Guard bit keeps +-2M from overflowing; after the 2-bit shift it is redundant.
  assign w_sum      = {r_acc[WIDTH+1], r_acc} + w_addend;
  assign w_acc_nxt  = {w_sum[WIDTH+2], w_sum[WIDTH+2:2]};
  assign w_mplr_nxt = {w_sum[1:0], r_mplr[WIDTH+2:2]};

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.Start) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.Start) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, Booth step/shift, and result capture on the final step.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
    end else if (w_accept) begin
      r_mcand <= w_mcand_ext;
      r_acc   <= '0;
      r_mplr  <= {w_mplr_ext, 1'b0};
      r_cnt   <= '0;
    end else if (w_step) begin
      r_acc  <= w_acc_nxt;
      r_mplr <= w_mplr_nxt;
      r_cnt  <= r_cnt + CNT_ONE;
      if (w_last) r_prod <= {w_acc_nxt[WIDTH-3:0], w_mplr_nxt[WIDTH+2:1]};
    end
  end

  assign bus.Busy    = (r_state == CALC);
  assign bus.Done    = (r_state == DONE);
  assign bus.Produto = r_prod;

endmodule
